// File: rtl/mdu_param.sv
// Multiply/divide unit for the E stage: holds HI/LO, runs signed/unsigned mult,
// div and multiply-accumulate with separate multiply and divide latencies.
module mdu_param #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rd_sel,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef logic [2*WIDTH-1:0] dword_t;

  logic [CW-1:0]    cnt;
  dword_t           pend;
  dword_t           res;
  logic             pend_div;
  logic             pend_dz;
  logic             is_arith;
  logic             is_div;
  logic             b_zero;

  dword_t           a_s, b_s, a_u, b_u, acc, prod_s, prod_u;
  logic [WIDTH-1:0] b_safe, abs_a, abs_b, q_mag, r_mag, quo_s, rem_s, quo_u, rem_u;

  assign a_s    = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_s    = {{WIDTH{b[WIDTH-1]}}, b};
  assign a_u    = {{WIDTH{1'b0}}, a};
  assign b_u    = {{WIDTH{1'b0}}, b};
  assign acc    = {hi, lo};
  assign prod_s = a_s * b_s;
  assign prod_u = a_u * b_u;

  // Divisor forced non-zero so the dividers never see 0; the zero case is
  // substituted below anyway.
  assign b_zero = (b == '0);
  assign b_safe = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b;
  assign quo_u  = a / b_safe;
  assign rem_u  = a % b_safe;

  // Signed divide on magnitudes; most-negative / -1 wraps back to a with rem 0.
  assign abs_a  = a[WIDTH-1] ? -a : a;
  assign abs_b  = b[WIDTH-1] ? -b_safe : b_safe;
  assign q_mag  = abs_a / abs_b;
  assign r_mag  = abs_a % abs_b;
  assign quo_s  = (a[WIDTH-1] ^ b[WIDTH-1]) ? -q_mag : q_mag;
  assign rem_s  = a[WIDTH-1] ? -r_mag : r_mag;

  assign is_arith = ~op[3];
  assign is_div   = (op[3:1] == 3'b001);

  always_comb begin
    res = '0;
    case (op)
      4'd0:    res = prod_s;
      4'd1:    res = prod_u;
      4'd2:    res = b_zero ? {a, {WIDTH{1'b1}}} : {rem_s, quo_s};
      4'd3:    res = b_zero ? {a, {WIDTH{1'b1}}} : {rem_u, quo_u};
      4'd4:    res = acc + prod_s;
      4'd5:    res = acc + prod_u;
      4'd6:    res = acc - prod_s;
      4'd7:    res = acc - prod_u;
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      pend     <= '0;
      pend_div <= 1'b0;
      pend_dz  <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        if (is_arith) begin
          pend     <= res;
          pend_div <= is_div;
          pend_dz  <= b_zero;
          cnt      <= is_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
        end else if (op == 4'd8) begin
          hi <= a;
        end else if (op == 4'd9) begin
          lo <= b;
        end
      end else if (busy) begin
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          {hi, lo} <= pend;
          done     <= 1'b1;
          if (pend_div) div_zero <= pend_dz;
        end
      end
    end
  end

  assign busy = (cnt != '0);
  assign out  = rd_sel ? hi : lo;

endmodule

// File: tb/tb_mdu_param.sv
// Directed and randomized checks of mdu_param against a 64-bit arithmetic
// reference model of HI/LO, latency and div_zero behaviour.
module tb_mdu_param;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        rd_sel = 1'b0;
  logic [31:0] out, hi, lo;
  logic        busy, done, div_zero;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;
  logic        dz_m = 1'b0;

  mdu_param #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .rd_sel(rd_sel), .out(out), .hi(hi), .lo(lo), .busy(busy),
    .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: applies one op to the model HI/LO, returns busy length.
  function automatic int model(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv);
    logic [63:0] acc = {hi_m, lo_m};
    longint      sa = longint'($signed(av));
    longint      sb = longint'($signed(bv));
    logic [63:0] ps = sa * sb;
    logic [63:0] pu = {32'b0, av} * {32'b0, bv};
    longint      q, r;
    int          cyc = 5;
    case (o)
      4'd0: acc = ps;
      4'd1: acc = pu;
      4'd4: acc = acc + ps;
      4'd5: acc = acc + pu;
      4'd6: acc = acc - ps;
      4'd7: acc = acc - pu;
      4'd2, 4'd3: begin
        cyc = 10;
        if (bv == 0) begin
          acc  = {av, 32'hFFFF_FFFF};
          dz_m = 1'b1;
        end else begin
          if (o == 4'd2) begin
            q = sa / sb;
            r = sa % sb;
          end else begin
            q = longint'({32'b0, av}) / longint'({32'b0, bv});
            r = longint'({32'b0, av}) % longint'({32'b0, bv});
          end
          acc  = {r[31:0], q[31:0]};
          dz_m = 1'b0;
        end
      end
      4'd8: begin acc[63:32] = av; cyc = 0; end
      4'd9: begin acc[31:0]  = bv; cyc = 0; end
      default: cyc = 0;
    endcase
    {hi_m, lo_m} = acc;
    return cyc;
  endfunction

  // Launch an arithmetic op at the next edge and follow it through commit.
  // With inject set, starts are also driven during the first busy cycles.
  task automatic run_op(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input bit inject);
    int          n = 0;
    int          exp_n;
    logic [31:0] hs = hi_m;
    logic [31:0] ls = lo_m;
    op = o; a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_n = model(o, av, bv);
    while (busy === 1'b1 && n < 200) begin
      n++;
      chk("done_busy", 32'(done), 32'd0);
      rd_sel = 1'($urandom);
      #1;
      chk("out_stale", out, rd_sel ? hs : ls);
      if (inject && n <= 3) begin
        start = 1'b1;
        op = (n == 1) ? 4'd2 : (n == 2) ? 4'd8 : (n == 3) ? 4'd12 : 4'($urandom);
        a = $urandom; b = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("busy_len", 32'(n), 32'(exp_n));
    chk("done_pulse", 32'(done), 32'd1);
    chk("hi", hi, hi_m);
    chk("lo", lo, lo_m);
    chk("div_zero", 32'(div_zero), 32'(dz_m));
  endtask

  // mthi/mtlo/reserved: immediate effect (or none), never busy or done.
  task automatic run_imm(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv);
    int unused;
    op = o; a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    unused = model(o, av, bv);
    chk("imm_busy", 32'(busy), 32'd0);
    chk("imm_done", 32'(done), 32'd0);
    chk("imm_hi", hi, hi_m);
    chk("imm_lo", lo, lo_m);
  endtask

  task automatic run_any(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input bit inject);
    if (o < 4'd8) run_op(o, av, bv, inject);
    else          run_imm(o, av, bv);
  endtask

  initial begin
    bit saw_done = 1'b0;
    #1;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dz", 32'(div_zero), 32'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // Reset while a divide is in flight, with state dirtied beforehand.
    run_imm(4'd8, 32'hDEAD_BEEF, 32'h0);
    run_imm(4'd9, 32'h0, 32'h1234_5678);
    run_op(4'd3, 32'h55, 32'h0, 1'b0);
    chk("t1_dz_pre", 32'(div_zero), 32'd1);
    op = 4'd2; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    hi_m = '0; lo_m = '0; dz_m = 1'b0;
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_hi", hi, 32'd0);
    chk("t1_lo", lo, 32'd0);
    chk("t1_dz", 32'(div_zero), 32'd0);
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
    end
    chk("t1_no_done", 32'(saw_done), 32'd0);

    // Multiply, signed then unsigned, then divides.
    run_op(4'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
    chk("t2_hi", hi, 32'hFFFF_FFFF);
    chk("t2_lo", lo, 32'hFFFF_FFFA);
    run_op(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    chk("t2u_hi", hi, 32'h0000_0002);
    run_op(4'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("t3_lo", lo, 32'hFFFF_FFFD);
    chk("t3_hi", hi, 32'hFFFF_FFFF);
    run_op(4'd3, 32'd7, 32'd2, 1'b0);
    chk("t3u_lo", lo, 32'd3);

    // Accumulate chain issued on the done cycle.
    run_op(4'd0, 32'd2, 32'd5, 1'b0);
    run_op(4'd4, 32'd4, 32'd5, 1'b0);
    chk("t4_lo", lo, 32'd30);
    chk("t4_hi", hi, 32'd0);
    run_op(4'd7, 32'd1, 32'd31, 1'b0);
    chk("t4s_lo", lo, 32'hFFFF_FFFF);
    chk("t4s_hi", hi, 32'hFFFF_FFFF);

    // Divide by zero and the overflow quotient.
    run_op(4'd3, 32'h1234, 32'd0, 1'b0);
    chk("t5_hi", hi, 32'h1234);
    chk("t5_dz", 32'(div_zero), 32'd1);
    run_op(4'd0, 32'd3, 32'd3, 1'b0);
    chk("t5_dz_keep", 32'(div_zero), 32'd1);
    run_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("t5_lo", lo, 32'h8000_0000);
    chk("t5_dz_clr", 32'(div_zero), 32'd0);

    // Starts during busy must be ignored.
    run_op(4'd0, 32'h0001_0003, 32'hFFFF_0007, 1'b1);

    // Randomized ops, with occasional injected starts while busy.
    for (int i = 0; i < 60; i++) begin
      logic [3:0]  ro = 4'($urandom_range(0, 15));
      logic [31:0] ra = $urandom;
      logic [31:0] rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 9) == 0) begin
        ra = 32'h8000_0000;
        rb = 32'hFFFF_FFFF;
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      run_any(ro, ra, rb, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mdu_param.md
Name: mdu_param

Overview:
- Parametrised multiply/divide unit for the pipelined MIPS core's E stage; successor to the fixed 32-bit mult/div unit.
- Holds HI/LO and executes signed and unsigned mult and div.
- Adds multiply-accumulate (madd/maddu/msub/msubu), configurable operand width, independent multiply and divide latencies, a done pulse and divide-by-zero reporting.
- Hazard unit stalls D on busy, or on a start while busy, exactly as today.

Parameters:
- WIDTH, 32: operand / HI / LO width in bits, >= 8.
- MUL_CYCLES, 5: busy cycles for mult/madd/msub family, >= 1.
- DIV_CYCLES, 10: busy cycles for div/divu, >= 1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  launch/commit op on this edge.
- op  input  4  0 mult, 1 multu, 2 div, 3 divu, 4 madd, 5 maddu, 6 msub, 7 msubu, 8 mthi, 9 mtlo, 10-15 reserved.
- a  input  WIDTH  rs operand (forwarded).
- b  input  WIDTH  rt operand (forwarded).
- rd_sel  input  1  0 = out shows LO, 1 = out shows HI.
- out  output  WIDTH  combinational mux of HI/LO per rd_sel.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse on the cycle HI/LO commit.
- div_zero  output  1  sticky flag: last div/divu had b == 0.

Behaviour:

Reset:
- reset low asynchronously clears HI, LO, counter, pending regs, busy, done and div_zero to 0.
- Reset mid-operation abandons the op; no commit and no done afterwards.

Idle (busy = 0) and start = 1 at a rising edge:
- Ops 0-7:
  - Capture a, b and op.
  - Compute the pending 2*WIDTH result from a, b and the current {HI,LO}.
  - Load the counter with MUL_CYCLES (ops 0,1,4-7) or DIV_CYCLES (ops 2,3).
- Op 8: HI <= a. Op 9: LO <= b. Both take effect that edge, with no busy and no done.
- Ops 10-15: no effect.

Busy and counter:
- busy = (counter != 0). It is high for exactly N cycles starting the cycle after the start edge.
- Each edge with counter > 0 decrements the counter.
- On the 1 -> 0 edge, {HI,LO} <= pending and done = 1 for the following cycle only.
- HI/LO keep their old values throughout busy, so mfhi/mflo during busy reads stale values; the stall prevents this.

start while busy:
- Ignored for every op, including mthi and mtlo; no state change.

Back-to-back ops:
- A start on the cycle done is high is accepted, because busy is already 0 then.
- That start sees the committed HI/LO, so madd chains work.

Arithmetic (all modulo 2^(2*WIDTH)):
- mult: signed a*b.
- multu: unsigned a*b.
- madd/maddu: {HI,LO} + a*b, signed or unsigned product respectively.
- msub/msubu: {HI,LO} - a*b, signed or unsigned product respectively.
- div: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
- div with a = most negative value and b = -1: LO = a, HI = 0.
- divu: unsigned quotient and remainder.

Divide by zero:
- Full latency still runs.
- Commits LO = all ones, HI = a.
- Sets div_zero at the commit edge.
- div_zero is cleared by the commit of the next div/divu with b != 0, or by reset.

Output path:
- out, hi and lo have no combinational path from a or b.
- out depends only on the registers and rd_sel.

Test Plan:
Defaults WIDTH=32, MUL_CYCLES=5, DIV_CYCLES=10.
1. Reset low mid-div (counter = 4), then high -> busy=0, done never pulses, HI=LO=0, div_zero=0.
2. mult a=0xFFFFFFFE (-2), b=3 -> busy high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; done high 1 cycle. Repeat as multu -> HI=0x00000002, LO=0xFFFFFFFA.
3. div a=-7 (0xFFFFFFF9), b=2 -> after 10 busy cycles LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu a=7, b=2 -> LO=3, HI=1.
4. mthi a=0, mtlo b=10, then madd a=4, b=5 issued on the done cycle of a prior mult -> LO=30, HI=0. Then msubu a=1, b=31 -> HI=0xFFFFFFFF, LO=0xFFFFFFFF.
5. divu a=0x1234, b=0 -> LO=0xFFFFFFFF, HI=0x1234, div_zero=1. Then div a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0, div_zero=0.
6. While busy from a mult: start with op=div, op=mthi, op=12 -> all ignored. HI/LO commit only the mult result, busy length unchanged; rd_sel toggling switches out between hi and lo the same cycle.
